forwarding_hazard_unit: RTL and testbench
=========================================

Name: forwarding_hazard_unit

Overview:
- Produces the operand-forwarding selects (sel_src1, sel_src2) consumed by the execute stage, and the load-use stall request consumed by the fetch/decode stages.
- Keeps its own shadow pipeline of register-usage info (EXE, MEM, WB slots), advanced in lockstep with the main pipeline registers.
- Sits beside the ID/EXE, EXE/MEM and MEM/WB registers. It is the source end of the execute stage's forwarding interface.

Parameters:
- REG_W, 4, register-number width (16 architectural registers).
- FWD_EN, 1, 1 = forwarding enabled; 0 = never forward, stall on every RAW hazard.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- freeze  in  1  global pipeline hold (memory wait); all slots hold
- flush  in  1  branch taken; ID instruction becomes a bubble in EXE
- id_src1  in  REG_W  Rn of instruction in ID
- id_src2  in  REG_W  Rm/Rd-store of instruction in ID
- id_two_src  in  1  ID instruction reads id_src2
- id_uses_src1  in  1  ID instruction reads id_src1 (0 for MOV/MVN/B)
- id_dest  in  REG_W  destination of ID instruction
- id_wb_en  in  1  ID instruction writes back
- id_mem_r_en  in  1  ID instruction is a load
- sel_src1  out  2  first-operand select for the EXE instruction
- sel_src2  out  2  second-operand select for the EXE instruction
- hazard_stall  out  1  hold PC and IF/ID; insert bubble into EXE

Behaviour:
- Select encoding (shared package): 2'd0 = register-file value, 2'd1 = MEM-stage ALU result, 2'd2 = WB-stage write value, 2'd3 is reserved and never driven.
- State: three slots, each {src1, src2, uses1, uses2, dest, wb_en, mem_r_en}.
  - exe_slot holds all fields.
  - mem_slot and wb_slot hold only {dest, wb_en, mem_r_en}.
- Reset (rst=1 at a clk edge):
  - All slot wb_en, mem_r_en, uses1 and uses2 clear to 0.
  - All slot register fields clear to 0.
  - sel_src1 = sel_src2 = 0 and hazard_stall = 0 combinationally thereafter.
  - Reset takes priority over freeze and flush.
- Advance (each clk edge, rst=0, freeze=0):
  - wb_slot <= mem_slot.
  - mem_slot <= exe_slot.
  - exe_slot <= ID info, or a bubble (wb_en=0, mem_r_en=0, uses1=0, uses2=0) if flush=1 or hazard_stall=1.
- Freeze (freeze=1, rst=0): all three slots hold. Freeze dominates flush and hazard_stall; those events are re-evaluated on the next unfrozen edge.
- Forwarding (combinational from slots, FWD_EN=1):
  - sel_src1 = 1 if exe.uses1 && mem.wb_en && mem.dest==exe.src1.
  - Otherwise sel_src1 = 2 if exe.uses1 && wb.wb_en && wb.dest==exe.src1.
  - Otherwise sel_src1 = 0.
  - sel_src2 follows the same rules on src2/uses2.
  - MEM beats WB when both match (youngest producer wins).
  - With FWD_EN=0, selects are constant 0.
- Hazard (combinational):
  - FWD_EN=1: hazard_stall = exe.mem_r_en && exe.wb_en && ((id_uses_src1 && exe.dest==id_src1) || (id_two_src && exe.dest==id_src2)).
  - FWD_EN=0: hazard_stall asserts on any match of an ID source against an exe or mem slot with wb_en=1.
  - While flush=1, hazard_stall is forced to 0 (the ID instruction is discarded anyway).
- Latency: selects are valid in the same cycle the instruction occupies EXE. A load-use stall lasts exactly 1 cycle with FWD_EN=1, and up to 2 cycles with FWD_EN=0.
- A load in MEM forwards its ALU result (the address) via sel=1 only if a dependent instruction is in EXE. The stall guarantees this never happens for load-use.

Decomposition:
- Package fwd_pkg holds:
  - SEL_RF=2'd0, SEL_MEM=2'd1, SEL_WB=2'd2.
  - A slot struct typedef.
  - The BUBBLE constant.
- One natural sub-module: fwd_select. It is the combinational comparator for one operand and is instantiated twice.
- The slot registers and stall logic live in the top module.

Test Plan:
- ADD R1 in ID, then SUB R2,R1,R3 next cycle, then ADD R4,R1,R1 next cycle -> SUB in EXE: sel_src1=1. The second ADD in EXE: sel_src1=2, sel_src2=2. hazard_stall stays 0.
- LDR R5 in EXE while ID reads R5 as src2 with id_two_src=1 -> hazard_stall=1 for 1 cycle. Bubble in EXE next cycle. The dependent instruction then gets sel_src2=2.
- Same producer R7 in both MEM and WB, with the EXE consumer reading R7 -> sel_src1=1 (MEM priority).
- freeze=1 for 3 cycles with a forwarding match active -> sel values unchanged across all frozen cycles. The slots shift only on the first edge after freeze drops.
- flush=1 while ID reads the dest of a load in EXE -> hazard_stall=0. The bubble enters EXE, and the next cycle's selects are all 0.
- rst=1 mid-stream with matches pending -> the next cycle sel_src1=sel_src2=0, hazard_stall=0. Rerun the first scenario with FWD_EN=0 -> 2-cycle stall, selects always 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: operand-select encoding,
// shadow-pipeline slot layouts and the bubble constant.
package fwd_pkg;

  localparam int SLOT_REG_W = 4;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  typedef struct packed {
    logic [SLOT_REG_W-1:0] src1;
    logic [SLOT_REG_W-1:0] src2;
    logic                  uses1;
    logic                  uses2;
    logic [SLOT_REG_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } exe_slot_t;

  // Later stages only need to know what they will write back.
  typedef struct packed {
    logic [SLOT_REG_W-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } res_slot_t;

  localparam exe_slot_t BUBBLE = '{
    src1:     {SLOT_REG_W{1'b0}},
    src2:     {SLOT_REG_W{1'b0}},
    uses1:    1'b0,
    uses2:    1'b0,
    dest:     {SLOT_REG_W{1'b0}},
    wb_en:    1'b0,
    mem_r_en: 1'b0
  };

  localparam res_slot_t RES_EMPTY = '{
    dest:     {SLOT_REG_W{1'b0}},
    wb_en:    1'b0,
    mem_r_en: 1'b0
  };

  function automatic res_slot_t to_res(input exe_slot_t s);
    res_slot_t r;
    r.dest     = s.dest;
    r.wb_en    = s.wb_en;
    r.mem_r_en = s.mem_r_en;
    return r;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand-select comparator for one EXE source: picks the youngest in-flight
// producer (MEM before WB) of the register, else the register file.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int REG_W  = SLOT_REG_W,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             uses,
  input  logic [REG_W-1:0] src,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             wb_wb_en,
  input  logic [REG_W-1:0] wb_dest,
  output logic [1:0]       sel
);

  // Priority select: MEM result is younger than WB result.
  always_comb begin
    sel = SEL_RF;
    if (!FWD_EN || !uses) begin
      sel = SEL_RF;
    end else if (mem_wb_en && (mem_dest == src)) begin
      sel = SEL_MEM;
    end else if (wb_wb_en && (wb_dest == src)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Shadow pipeline of register usage (EXE/MEM/WB) driving the execute-stage
// operand selects and the load-use stall request.
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_W  = SLOT_REG_W,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             id_uses_src1,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             hazard_stall
);

  exe_slot_t exe_slot_r;
  res_slot_t mem_slot_r;
  res_slot_t wb_slot_r;
  exe_slot_t id_slot_s;
  logic      raw_exe_s;
  logic      raw_mem_s;
  logic      hazard_stall_s;

  function automatic logic id_reads(input logic             uses1,
                                    input logic [REG_W-1:0] src1,
                                    input logic             two_src,
                                    input logic [REG_W-1:0] src2,
                                    input logic [REG_W-1:0] dest);
    return (uses1 && (src1 == dest)) || (two_src && (src2 == dest));
  endfunction

  // Pack the decoding instruction into slot form.
  always_comb begin
    id_slot_s          = BUBBLE;
    id_slot_s.src1     = id_src1;
    id_slot_s.src2     = id_src2;
    id_slot_s.uses1    = id_uses_src1;
    id_slot_s.uses2    = id_two_src;
    id_slot_s.dest     = id_dest;
    id_slot_s.wb_en    = id_wb_en;
    id_slot_s.mem_r_en = id_mem_r_en;
  end

  // RAW detection; without forwarding any in-flight producer in EXE or MEM
  // blocks the ID instruction, with forwarding only a load in EXE does.
  always_comb begin
    raw_exe_s = exe_slot_r.wb_en &&
                id_reads(id_uses_src1, id_src1, id_two_src, id_src2, exe_slot_r.dest);
    raw_mem_s = mem_slot_r.wb_en &&
                id_reads(id_uses_src1, id_src1, id_two_src, id_src2, mem_slot_r.dest);
    if (flush) begin
      hazard_stall_s = 1'b0;
    end else if (FWD_EN) begin
      hazard_stall_s = raw_exe_s && exe_slot_r.mem_r_en;
    end else begin
      hazard_stall_s = raw_exe_s || raw_mem_s;
    end
  end

  assign hazard_stall = hazard_stall_s;

  // Shadow pipeline advance; freeze holds every slot including on flush/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_slot_r <= BUBBLE;
      mem_slot_r <= RES_EMPTY;
      wb_slot_r  <= RES_EMPTY;
    end else if (!freeze) begin
      wb_slot_r  <= mem_slot_r;
      mem_slot_r <= to_res(exe_slot_r);
      exe_slot_r <= (flush || hazard_stall_s) ? BUBBLE : id_slot_s;
    end else begin
      exe_slot_r <= exe_slot_r;
      mem_slot_r <= mem_slot_r;
      wb_slot_r  <= wb_slot_r;
    end
  end

  fwd_select #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_sel_src1 (
    .uses      (exe_slot_r.uses1),
    .src       (exe_slot_r.src1),
    .mem_wb_en (mem_slot_r.wb_en),
    .mem_dest  (mem_slot_r.dest),
    .wb_wb_en  (wb_slot_r.wb_en),
    .wb_dest   (wb_slot_r.dest),
    .sel       (sel_src1)
  );

  fwd_select #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_sel_src2 (
    .uses      (exe_slot_r.uses2),
    .src       (exe_slot_r.src2),
    .mem_wb_en (mem_slot_r.wb_en),
    .mem_dest  (mem_slot_r.dest),
    .wb_wb_en  (wb_slot_r.wb_en),
    .wb_dest   (wb_slot_r.dest),
    .sel       (sel_src2)
  );

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench: two units (forwarding on/off) share one random instruction
// stream; a pipeline-level model predicts selects and stalls for each.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, freeze, flush;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_two_src, id_uses_src1, id_wb_en, id_mem_r_en;
  logic [1:0] f_sel1, f_sel2, n_sel1, n_sel2;
  logic       f_stall, n_stall;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.REG_W(4), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_uses_src1(id_uses_src1), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .sel_src1(f_sel1), .sel_src2(f_sel2),
    .hazard_stall(f_stall));

  forwarding_hazard_unit #(.REG_W(4), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_uses_src1(id_uses_src1), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .sel_src1(n_sel1), .sel_src2(n_sel2),
    .hazard_stall(n_stall));

  // An instruction in flight; an all-zero record is a bubble.
  typedef struct {
    logic [3:0] s1, s2, d;
    bit         u1, u2, wb, ld;
  } ins_t;
  typedef ins_t pipe_t[3];   // [0]=EXE, [1]=MEM, [2]=WB

  typedef struct {
    logic [1:0] f1, f2, n1, n2;
    logic       fs, ns;
  } exp_t;

  pipe_t pf, pn;
  exp_t  sbq[$];
  int    n_total = 0;
  int    n_pass  = 0;
  bit    done    = 1'b0;

  function automatic ins_t empty_ins();
    ins_t z;
    z.s1 = 4'd0; z.s2 = 4'd0; z.d = 4'd0;
    z.u1 = 1'b0; z.u2 = 1'b0; z.wb = 1'b0; z.ld = 1'b0;
    return z;
  endfunction

  // Youngest older producer of the EXE operand: distance 1 is MEM, 2 is WB.
  function automatic logic [1:0] exp_sel(input pipe_t p, input bit fwd, input bit second);
    logic [3:0] r;
    bit         u;
    r = second ? p[0].s2 : p[0].s1;
    u = second ? p[0].u2 : p[0].u1;
    if (!fwd || !u) return 2'd0;
    for (int k = 1; k <= 2; k++)
      if (p[k].wb && p[k].d == r) return k[1:0];
    return 2'd0;
  endfunction

  function automatic bit exp_stall(input pipe_t p, input ins_t id, input bit fwd, input bit fl);
    bit hit = 1'b0;
    if (fl) return 1'b0;
    for (int k = 0; k <= 1; k++) begin
      if (p[k].wb && ((id.u1 && id.s1 == p[k].d) || (id.u2 && id.s2 == p[k].d))) begin
        if (!fwd) hit = 1'b1;
        else if (k == 0 && p[k].ld) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic pipe_t next_pipe(input pipe_t p, input ins_t id, input bit stall,
                                      input bit fl, input bit fz, input bit r);
    pipe_t q;
    q = p;
    if (r) begin
      for (int k = 0; k < 3; k++) q[k] = empty_ins();
    end else if (!fz) begin
      q[2] = p[1];
      q[1] = p[0];
      q[0] = (fl || stall) ? empty_ins() : id;
    end
    return q;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive ID, push the prediction, advance the models.
  task automatic step(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                      input bit u1, input bit two, input bit wb, input bit ld,
                      input bit fl, input bit fz, input bit r);
    ins_t  id;
    exp_t  e;
    pipe_t nf, nn;
    id_src1 = s1; id_src2 = s2; id_dest = d;
    id_uses_src1 = u1; id_two_src = two; id_wb_en = wb; id_mem_r_en = ld;
    flush = fl; freeze = fz; rst = r;
    id.s1 = s1; id.s2 = s2; id.d = d; id.u1 = u1; id.u2 = two; id.wb = wb; id.ld = ld;
    e.f1 = exp_sel(pf, 1'b1, 1'b0);
    e.f2 = exp_sel(pf, 1'b1, 1'b1);
    e.fs = exp_stall(pf, id, 1'b1, fl);
    e.n1 = exp_sel(pn, 1'b0, 1'b0);
    e.n2 = exp_sel(pn, 1'b0, 1'b1);
    e.ns = exp_stall(pn, id, 1'b0, fl);
    sbq.push_back(e);
    nf = next_pipe(pf, id, e.fs, fl, fz, r);
    nn = next_pipe(pn, id, e.ns, fl, fz, r);
    @(posedge clk);
    #1;
    pf = nf;
    pn = nn;
  endtask

  task automatic nop();
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle and compared mid-cycle.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("fwd_sel_src1", f_sel1, e.f1);
        check("fwd_sel_src2", f_sel2, e.f2);
        check("fwd_stall", {1'b0, f_stall}, {1'b0, e.fs});
        check("nofwd_sel_src1", n_sel1, e.n1);
        check("nofwd_sel_src2", n_sel2, e.n2);
        check("nofwd_stall", {1'b0, n_stall}, {1'b0, e.ns});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fz_left = 0;
    for (int k = 0; k < 3; k++) begin
      pf[k] = empty_ins();
      pn[k] = empty_ins();
    end
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    id_src1 = 4'd0; id_src2 = 4'd0; id_dest = 4'd0;
    id_two_src = 1'b0; id_uses_src1 = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // ADD R1 ; SUB R2,R1,R3 ; ADD R4,R1,R1
    step(4'd2, 4'd3, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd1, 4'd3, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd1, 4'd1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) nop();
    // LDR R5 then a consumer of R5 as src2, held while stalled
    step(4'd6, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'd0, 4'd5, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) nop();
    // R7 produced twice back to back, then consumed
    step(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd7, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // freeze with a match active
    repeat (3) step(4'd9, 4'd7, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) nop();
    // flush while ID reads a load destination in EXE
    step(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd2, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) nop();
    // reset mid-stream with matches pending
    step(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd1, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) nop();
    // randomized stream over a small register set to provoke many hazards
    for (int c = 0; c < 800; c++) begin
      bit fz;
      if (fz_left > 0) fz_left--;
      else if ($urandom_range(0, 9) == 0) fz_left = $urandom_range(1, 3);
      fz = (fz_left > 0);
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 4) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, fz, $urandom_range(0, 49) == 0);
    end
    repeat (3) @(negedge clk);
    n_total++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
